// File: rtl/cnn_pkg.sv
// Shared CNN datapath types.
//   LANES / LANE_W : OFM word packing, lane k at bits [8k+7:8k]
//   OFM_DEPTH      : words stored in one OFM memory
//   rd_state_t     : OFM window-reader sequencing states
//   ofm_beat_t     : one streamed OFM word plus its position flags
package cnn_pkg;

  localparam int LANES     = 4;
  localparam int LANE_W    = 8;
  localparam int OFM_DEPTH = 172;
  localparam int WORD_W    = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } rd_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              row_last;
    logic              win_last;
    logic              last;
  } ofm_beat_t;

endpackage

// File: rtl/ofm_window_reader_fifo2.sv
// fifo2: 2-entry synchronous FIFO.
//   clk, rst (active-low, synchronous)
//   push / push_data : write one entry
//   pop / pop_data   : pop_data is the head entry, pop advances it
//   count            : entries held (0..2)
// Storage is cleared on reset so an empty FIFO presents all-zero data.
module fifo2 #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Defensive guards: a pop on empty or a push on full without a pop is dropped.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ofm_window_reader.sv
// ofm_window_reader: streams a stored 4-lane feature map in row-window
// order (window, then row, then column) over a valid/ready handshake.
//   clk, rst (active-low, synchronous), start
//   mem_rd_en / mem_addr / mem_data : OFM read port, data 1 cycle after strobe
//   out_valid / out_ready / out_data : stream to the next layer
//   out_row_last / out_win_last / out_last : position flags of the beat
//   busy : pass in progress, done : one-cycle pulse after the final beat
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing reads while FIFO + in-flight space allows
// DRAIN | all reads issued, waiting for the last beat to be accepted
// DONE  | pulsing done, back to IDLE next cycle
module ofm_window_reader
  import cnn_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int ROW_LEN = 4,
  parameter int ROW_CNT = 43,
  parameter int WIN_H   = 4,
  parameter int STRIDE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_row_last,
  output logic              out_win_last,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int NWIN = (ROW_CNT - WIN_H) / STRIDE + 1;

  localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(ROW_LEN - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(WIN_H - 1);
  localparam logic [ADDR_W-1:0] WIN_MAX  = ADDR_W'(NWIN - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_LEN);
  localparam logic [ADDR_W-1:0] WIN_STEP = ADDR_W'(STRIDE * ROW_LEN);

  rd_state_t         state;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] win;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] win_base;
  logic              inflight;
  logic [2:0]        inflight_flags;

  ofm_beat_t push_beat;
  ofm_beat_t head;
  logic [1:0] fifo_count;
  logic [2:0] occupancy;
  logic       pop;
  logic       issue;
  logic       is_row_last;
  logic       is_win_last;
  logic       is_last;

  assign is_row_last = (col == COL_MAX);
  assign is_win_last = is_row_last && (row == ROW_MAX);
  assign is_last     = is_win_last && (win == WIN_MAX);

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Words held or on their way after this cycle's pop; a new read must
  // still find a FIFO slot when its data lands next cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == ISSUE) && (occupancy < 3'd2);

  assign mem_rd_en = issue;
  assign mem_addr  = addr;

  assign push_beat.data     = mem_data;
  assign push_beat.row_last = inflight_flags[2];
  assign push_beat.win_last = inflight_flags[1];
  assign push_beat.last     = inflight_flags[0];

  fifo2 #(
    .W($bits(ofm_beat_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(push_beat),
    .pop      (pop),
    .pop_data (head),
    .count    (fifo_count)
  );

  assign out_data     = out_valid ? head.data : 32'd0;
  assign out_row_last = out_valid & head.row_last;
  assign out_win_last = out_valid & head.win_last;
  assign out_last     = out_valid & head.last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      col            <= '0;
      row            <= '0;
      win            <= '0;
      addr           <= '0;
      row_base       <= '0;
      win_base       <= '0;
      inflight       <= 1'b0;
      inflight_flags <= 3'b000;
    end else begin
      inflight <= issue;
      if (issue) inflight_flags <= {is_row_last, is_win_last, is_last};
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end

        ISSUE: begin
          if (issue) begin
            if (is_last) begin
              // Counters park at zero so they never step past the map.
              state    <= DRAIN;
              col      <= '0;
              row      <= '0;
              win      <= '0;
              addr     <= '0;
              row_base <= '0;
              win_base <= '0;
            end else if (!is_row_last) begin
              col  <= col + 1'b1;
              addr <= addr + 1'b1;
            end else if (!is_win_last) begin
              col      <= '0;
              row      <= row + 1'b1;
              row_base <= row_base + ROW_STEP;
              addr     <= row_base + ROW_STEP;
            end else begin
              col      <= '0;
              row      <= '0;
              win      <= win + 1'b1;
              win_base <= win_base + WIN_STEP;
              row_base <= win_base + WIN_STEP;
              addr     <= win_base + WIN_STEP;
            end
          end
        end

        DRAIN: begin
          if (pop && head.last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_window_reader.sv
module tb_ofm_window_reader;

  localparam int ROW_LEN = 4;
  localparam int ROW_CNT = 43;
  localparam int WIN_H   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        out_ready;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_row_last, out_win_last, out_last, busy, done;

  logic        s2_start;
  logic        s2_ready;
  logic        s2_rd_en;
  logic [7:0]  s2_addr;
  logic [31:0] s2_mem_data = '0;
  logic        s2_valid;
  logic [31:0] s2_data;
  logic        s2_row_last, s2_win_last, s2_last, s2_busy, s2_done;

  logic [31:0] mem_img [256];

  ofm_window_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_last(out_row_last), .out_win_last(out_win_last), .out_last(out_last),
    .busy(busy), .done(done)
  );

  ofm_window_reader #(.STRIDE(2)) dut_s2 (
    .clk(clk), .rst(rst), .start(s2_start),
    .mem_rd_en(s2_rd_en), .mem_addr(s2_addr), .mem_data(s2_mem_data),
    .out_valid(s2_valid), .out_ready(s2_ready), .out_data(s2_data),
    .out_row_last(s2_row_last), .out_win_last(s2_win_last), .out_last(s2_last),
    .busy(s2_busy), .done(s2_done)
  );

  // OFM memory models with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem_img[mem_addr];
    if (s2_rd_en) s2_mem_data <= mem_img[s2_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [34:0] got_q [$];
  logic [34:0] exp_q [$];

  int cyc, done_cnt, done_cyc, last_cyc, first_valid, hold_n, outstanding;
  int rdy_mode;
  bit hold_final, prev_stall, glitched;
  logic [34:0] held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference order from the window/row/column definition.
  task automatic build_exp(input int stride);
    int nwin;
    int a;
    exp_q.delete();
    nwin = (ROW_CNT - WIN_H) / stride + 1;
    for (int w = 0; w < nwin; w++)
      for (int r = 0; r < WIN_H; r++)
        for (int c = 0; c < ROW_LEN; c++) begin
          a = (w * stride + r) * ROW_LEN + c;
          exp_q.push_back({mem_img[a], c == ROW_LEN - 1,
                           (c == ROW_LEN - 1) && (r == WIN_H - 1),
                           (c == ROW_LEN - 1) && (r == WIN_H - 1) && (w == nwin - 1)});
        end
  endtask

  task automatic cmp_beats(input int n_limit);
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    if (n_limit >= 0 && n > n_limit) n = n_limit;
    for (int i = 0; i < n; i++) chk($sformatf("beat%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic observe();
    logic pop;
    pop = out_valid & out_ready;
    if (prev_stall)
      chk("stall_hold", {out_valid, out_data, out_row_last, out_win_last, out_last}, {1'b1, held});
    if (mem_rd_en) chk("rd_cap", 64'((outstanding - int'(pop)) < 2), 64'd1);
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (pop) begin
      got_q.push_back({out_data, out_row_last, out_win_last, out_last});
      if (out_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    outstanding = outstanding + int'(mem_rd_en) - int'(pop);
    prev_stall = out_valid & ~out_ready;
    held = {out_data, out_row_last, out_win_last, out_last};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b1;
    if (hold_final && out_valid && out_last && hold_n < 5) begin
      out_ready = 1'b0;
      hold_n++;
    end
    @(negedge clk);
    observe();
  endtask

  task automatic run_pass(input int mode, input bit hold_last, input int glitch_beat,
                          input int abort_beat, input bit chk_timing);
    got_q.delete();
    done_cnt = 0; done_cyc = -1; last_cyc = -1; first_valid = -1;
    hold_n = 0; cyc = 0; glitched = 0;
    rdy_mode = mode; hold_final = hold_last;
    start = 1'b1;
    step();
    if (chk_timing) begin
      chk("c1_busy", 64'(busy), 64'd1);
      chk("c1_rd_en", 64'(mem_rd_en), 64'd1);
      chk("c1_addr", 64'(mem_addr), 64'd0);
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      if (abort_beat >= 0 && got_q.size() >= abort_beat) break;
      if (glitch_beat >= 0 && !glitched && got_q.size() >= glitch_beat) begin
        start = 1'b1;
        glitched = 1;
      end
      step();
    end
  endtask

  task automatic post_pass_checks(input string nm);
    int wl, ll, li;
    wl = 0; ll = 0; li = -1;
    foreach (got_q[i]) begin
      if (got_q[i][1]) wl++;
      if (got_q[i][0]) begin ll++; li = i; end
    end
    chk({nm, "_done_seen"}, 64'(done_cnt), 64'd1);
    chk({nm, "_beats"}, 64'(got_q.size()), 64'd640);
    chk({nm, "_win_last"}, 64'(wl), 64'd40);
    chk({nm, "_last_cnt"}, 64'(ll), 64'd1);
    chk({nm, "_last_idx"}, 64'(li), 64'd639);
    chk({nm, "_done_lat"}, 64'(done_cyc), 64'(last_cyc + 1));
    build_exp(1);
    cmp_beats(-1);
    step();
    chk({nm, "_busy_clr"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int s2_done_seen;
    int s2_last_addr;
    int s2_wl;
    int n_after;
    for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; s2_start = 1'b0; s2_ready = 1'b1;
    rdy_mode = 0; hold_final = 0; prev_stall = 0; outstanding = 0; cyc = 0;
    held = '0; hold_n = 0; done_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {mem_rd_en, mem_addr, out_valid, out_data, out_row_last, out_win_last,
                     out_last, busy, done}, 64'd0);
    chk("rst_outs_s2", {s2_rd_en, s2_addr, s2_valid, s2_data, s2_row_last, s2_win_last,
                        s2_last, s2_busy, s2_done}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Full pass with out_ready held high.
    run_pass(0, 0, -1, -1, 1);
    chk("first_valid_cyc", 64'(first_valid), 64'd3);
    chk("last_beat_cyc", 64'(last_cyc), 64'd642);
    chk("done_cyc", 64'(done_cyc), 64'd643);
    post_pass_checks("p0");

    // Random backpressure.
    run_pass(1, 0, -1, -1, 1);
    post_pass_checks("rand");

    // Ignored start at beat 100, final beat held off for 5 cycles.
    run_pass(0, 1, 100, -1, 1);
    chk("hold_cycles", 64'(hold_n), 64'd5);
    chk("glitch_sent", 64'(glitched), 64'd1);
    post_pass_checks("hold");

    // Reset mid-pass with a read in flight.
    run_pass(0, 0, -1, 50, 1);
    chk("abort_inflight", 64'(mem_rd_en), 64'd1);
    build_exp(1);
    cmp_beats(50);
    n_after = got_q.size();
    rst = 1'b0;
    step();
    chk("midrst_outs", {mem_rd_en, mem_addr, out_valid, out_data, out_row_last, out_win_last,
                        out_last, busy, done}, 64'd0);
    rst = 1'b1;
    outstanding = 0;
    prev_stall = 0;
    repeat (3) begin
      step();
      chk("no_stale", 64'(out_valid), 64'd0);
    end
    chk("no_stale_beats", 64'(got_q.size()), 64'(n_after));
    run_pass(0, 0, -1, -1, 1);
    chk("restart_first", 64'(first_valid), 64'd3);
    post_pass_checks("restart");

    // STRIDE=2 instance.
    got_q.delete();
    s2_done_seen = 0; s2_last_addr = -1; s2_wl = 0;
    @(negedge clk);
    s2_start = 1'b1;
    @(posedge clk);
    #1 s2_start = 1'b0;
    for (int i = 0; i < 1000 && s2_done_seen == 0; i++) begin
      @(negedge clk);
      if (s2_rd_en) s2_last_addr = int'(s2_addr);
      if (s2_valid && s2_ready) begin
        got_q.push_back({s2_data, s2_row_last, s2_win_last, s2_last});
        if (s2_win_last) s2_wl++;
      end
      if (s2_done) s2_done_seen = 1;
    end
    chk("s2_done_seen", 64'(s2_done_seen), 64'd1);
    chk("s2_beats", 64'(got_q.size()), 64'd320);
    chk("s2_last_addr", 64'(s2_last_addr), 64'd167);
    chk("s2_win_last", 64'(s2_wl), 64'd20);
    build_exp(2);
    cmp_beats(-1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
